// File: rtl/pc_seq_unit.sv
// Program counter sequencer: step/stop/branch with optional return-address stack (PC_SEQ_STACK_EN).
// Latency: pc updates one edge after a request; next_pc is combinational with no edge of delay.
// Backpressure: none; stop_en freezes pc, stack and flags, power=0 acts as a synchronous soft reset.
module pc_seq_unit #(
    parameter int          PC_W     = 8,
    parameter int          STACK_D  = 4,
    parameter logic [31:0] RESET_PC = 32'd0,
    parameter logic [31:0] STEP     = 32'd1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            power,
    input  logic            stop_en,
    input  logic            branch_en,
    input  logic            branch_rel,
    input  logic [PC_W-1:0] branch_pc,
    input  logic            call_en,
    input  logic            ret_en,
    output logic [PC_W-1:0] pc,
    output logic [PC_W-1:0] next_pc,
    output logic            stack_ovf,
    output logic            stack_unf
);
    localparam logic [PC_W-1:0] LP_RESET_PC = RESET_PC[PC_W-1:0];
    localparam logic [PC_W-1:0] LP_STEP     = STEP[PC_W-1:0];

    logic [PC_W-1:0] r_pc;
    logic [PC_W-1:0] w_seq;
    logic [PC_W-1:0] w_target;

    // Relative targets rely on modulo-2^PC_W addition to apply a two's complement offset.
    assign w_seq    = r_pc + LP_STEP;
    assign w_target = branch_rel ? (r_pc + branch_pc) : branch_pc;
    assign pc       = r_pc;

`ifdef PC_SEQ_STACK_EN
    localparam int SP_W  = $clog2(STACK_D + 1);
    localparam int IDX_W = (STACK_D > 1) ? $clog2(STACK_D) : 1;

    logic [PC_W-1:0]  r_stack [STACK_D];
    logic [SP_W-1:0]  r_sp;
    logic             r_ovf;
    logic             r_unf;
    logic             w_empty;
    logic             w_full;
    logic             w_do_ret;
    logic             w_do_call;
    logic [IDX_W-1:0] w_top_idx;
    logic [IDX_W-1:0] w_push_idx;

    assign w_empty    = (r_sp == '0);
    assign w_full     = (r_sp == SP_W'(STACK_D));
    assign w_top_idx  = IDX_W'(r_sp - SP_W'(1));
    assign w_push_idx = IDX_W'(r_sp);
    assign stack_ovf  = r_ovf;
    assign stack_unf  = r_unf;

    always_comb begin
        next_pc   = w_seq;
        w_do_ret  = 1'b0;
        w_do_call = 1'b0;
        if (!power) begin
            next_pc = LP_RESET_PC;
        end else if (stop_en) begin
            next_pc = r_pc;
        end else if (ret_en) begin
            w_do_ret = 1'b1;
            next_pc  = w_empty ? w_seq : r_stack[w_top_idx];
        end else if (call_en) begin
            w_do_call = 1'b1;
            next_pc   = w_target;
        end else if (branch_en) begin
            next_pc = w_target;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc  <= LP_RESET_PC;
            r_sp  <= '0;
            r_ovf <= 1'b0;
            r_unf <= 1'b0;
        end else begin
            r_pc <= next_pc;
            if (!power) begin
                r_sp  <= '0;
                r_ovf <= 1'b0;
                r_unf <= 1'b0;
            end else if (w_do_ret) begin
                if (w_empty) r_unf <= 1'b1;
                else         r_sp  <= r_sp - SP_W'(1);
            end else if (w_do_call) begin
                if (w_full) r_ovf <= 1'b1;
                else        r_sp  <= r_sp + SP_W'(1);
            end
        end
    end

    // Entry contents need no reset; only the pointer defines validity.
    always_ff @(posedge clk) begin
        if (w_do_call && !w_full) begin
            r_stack[w_push_idx] <= w_seq;
        end
    end
`else
    logic w_unused;
    assign w_unused  = ret_en | (STACK_D == 0);
    assign stack_ovf = 1'b0;
    assign stack_unf = 1'b0;

    always_comb begin
        next_pc = w_seq;
        if (!power) begin
            next_pc = LP_RESET_PC;
        end else if (stop_en) begin
            next_pc = r_pc;
        end else if (call_en || branch_en) begin
            next_pc = w_target;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_pc <= LP_RESET_PC;
        else     r_pc <= next_pc;
    end
`endif
endmodule

// File: tb/tb_pc_seq_unit.sv
// Bench for pc_seq_unit: queue-based reference model checked every negedge plus directed literal checks.
module tb_pc_seq_unit;
`ifdef PC_SEQ_STACK_EN
    localparam bit STK = 1'b1;
`else
    localparam bit STK = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       power = 1'b0;
    logic       stop_en = 1'b0;
    logic       branch_en = 1'b0;
    logic       branch_rel = 1'b0;
    logic [7:0] branch_pc = 8'h00;
    logic       call_en = 1'b0;
    logic       ret_en = 1'b0;
    logic [7:0] pc;
    logic [7:0] next_pc;
    logic       stack_ovf;
    logic       stack_unf;

    int n_chk = 0;
    int n_fail = 0;

    pc_seq_unit #(.PC_W(8), .STACK_D(4), .RESET_PC(32'd0), .STEP(32'd1)) dut (
        .clk(clk), .rst(rst), .power(power), .stop_en(stop_en),
        .branch_en(branch_en), .branch_rel(branch_rel), .branch_pc(branch_pc),
        .call_en(call_en), .ret_en(ret_en), .pc(pc), .next_pc(next_pc),
        .stack_ovf(stack_ovf), .stack_unf(stack_unf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference model: pc, a queue as the return stack, and sticky flags.
    logic [7:0] m_pc = 8'h00;
    logic [7:0] m_stk[$];
    logic       m_ovf = 1'b0;
    logic       m_unf = 1'b0;

    always @(negedge clk) begin
        logic [7:0] seq;
        logic [7:0] tgt;
        logic [7:0] e;
        if (rst) begin
            m_pc = 8'h00;
            m_stk.delete();
            m_ovf = 1'b0;
            m_unf = 1'b0;
            chk("model_rst_pc", pc, 8'h00);
        end else begin
            chk("model_pc", pc, m_pc);
            chk("model_ovf", stack_ovf, m_ovf);
            chk("model_unf", stack_unf, m_unf);
            seq = m_pc + 8'd1;
            tgt = branch_rel ? m_pc + branch_pc : branch_pc;
            if (!power) begin
                e = 8'h00;
                m_stk.delete();
                m_ovf = 1'b0;
                m_unf = 1'b0;
            end else if (stop_en) begin
                e = m_pc;
            end else if (STK && ret_en) begin
                if (m_stk.size() == 0) begin
                    e = seq;
                    m_unf = 1'b1;
                end else begin
                    e = m_stk.pop_back();
                end
            end else if (STK && call_en) begin
                if (m_stk.size() == 4) m_ovf = 1'b1;
                else m_stk.push_back(seq);
                e = tgt;
            end else if (call_en || branch_en) begin
                e = tgt;
            end else begin
                e = seq;
            end
            chk("model_next_pc", next_pc, e);
            m_pc = e;
        end
    end

    initial begin
        logic [7:0] ret_exp [5];
        if (STK) ret_exp = '{8'h32, 8'h22, 8'h12, 8'h02, 8'h03};
        else     ret_exp = '{8'h81, 8'h82, 8'h83, 8'h84, 8'h85};

        step();
        chk("reset_pc", pc, 8'h00);
        chk("reset_ovf", stack_ovf, 1'b0);
        chk("reset_unf", stack_unf, 1'b0);

        rst = 1'b0;
        power = 1'b1;
        chk("count_0", pc, 8'h00);
        for (int i = 1; i <= 5; i++) begin
            step();
            chk("count", pc, i);
        end

        branch_en = 1'b1; branch_pc = 8'h40;
        step();
        chk("branch_abs", pc, 8'h40);
        branch_en = 1'b0; stop_en = 1'b1; ret_en = 1'b1; call_en = 1'b1;
        #1 chk("stop_next_pc", next_pc, 8'h40);
        step();
        chk("stop_pc1", pc, 8'h40);
        chk("stop_next_pc1", next_pc, 8'h40);
        step();
        chk("stop_pc2", pc, 8'h40);
        chk("stop_unf", stack_unf, 1'b0);
        stop_en = 1'b0; ret_en = 1'b0; call_en = 1'b0;

        branch_en = 1'b1; branch_pc = 8'h10;
        step();
        branch_rel = 1'b1; branch_pc = 8'hFE;
        step();
        chk("rel_neg", pc, 8'h0E);
        branch_pc = 8'h05;
        step();
        chk("rel_pos", pc, 8'h13);
        branch_rel = 1'b0; branch_pc = 8'hFF;
        step();
        branch_en = 1'b0;
        step();
        chk("wrap", pc, 8'h00);

        for (int i = 0; i < 5; i++) begin
            branch_en = 1'b1; branch_pc = 8'h01 + 8'(i * 16);
            step();
            branch_en = 1'b0; call_en = 1'b1; branch_pc = 8'h80;
            step();
            call_en = 1'b0;
            chk("call_pc", pc, 8'h80);
            chk("call_ovf", stack_ovf, STK && (i == 4));
        end
        ret_en = 1'b1;
        for (int j = 0; j < 5; j++) begin
            step();
            chk("ret_pc", pc, ret_exp[j]);
            chk("ret_unf", stack_unf, STK && (j == 4));
        end
        ret_en = 1'b0;

        call_en = 1'b1; branch_pc = 8'h20;
        step();
        branch_pc = 8'h30;
        step();
        call_en = 1'b0; power = 1'b0;
        step();
        chk("pwr_pc", pc, 8'h00);
        chk("pwr_ovf", stack_ovf, 1'b0);
        chk("pwr_unf", stack_unf, 1'b0);
        power = 1'b1; ret_en = 1'b1;
        step();
        chk("pwr_ret_pc", pc, 8'h01);
        chk("pwr_ret_unf", stack_unf, STK);
        ret_en = 1'b0;

        call_en = 1'b1; branch_pc = 8'h50;
        step();
        ret_en = 1'b1; branch_pc = 8'h70;
        step();
        chk("ret_call", pc, STK ? 8'h02 : 8'h70);
        ret_en = 1'b0; call_en = 1'b0;

        branch_en = 1'b1; branch_pc = 8'h33;
        step();
        chk("pre_rst_pc", pc, 8'h33);
        branch_en = 1'b0;
        #2 rst = 1'b1;
        #1 chk("async_rst_pc", pc, 8'h00);
        chk("async_rst_unf", stack_unf, 1'b0);
        step();
        rst = 1'b0;
        step();
        chk("post_rst_pc", pc, 8'h01);
        step();
        step();

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
